// File: rtl/puf_uart_link_if.sv
// puf_uart_link_if: UART byte port, PUF core port and link status
// signals of puf_uart_link, with link-side and environment-side modports.
interface puf_uart_link_if #(
   parameter int CHAL_BYTES = 8,
   parameter int RESP_BYTES = 4
);
   logic [7:0]              rec_dataH;
   logic                    rec_readyH;
   logic                    xmitH;
   logic [7:0]              xmit_dataH;
   logic                    xmit_doneH;
   logic [8*CHAL_BYTES-1:0] puf_challenge;
   logic                    puf_startH;
   logic                    puf_doneH;
   logic [8*RESP_BYTES-1:0] puf_response;
   logic                    link_busyH;
   logic                    frame_errH;

   // link controller side
   modport master (
      input  rec_dataH, rec_readyH, xmit_doneH,
      input  puf_doneH, puf_response,
      output xmitH, xmit_dataH, puf_challenge,
      output puf_startH, link_busyH, frame_errH
   );

   // UART / PUF environment side
   modport slave (
      output rec_dataH, rec_readyH, xmit_doneH,
      output puf_doneH, puf_response,
      input  xmitH, xmit_dataH, puf_challenge,
      input  puf_startH, link_busyH, frame_errH
   );
endinterface

// File: rtl/puf_uart_link.sv
// puf_uart_link: framed challenge receive, PUF launch and framed reply.
// Optional macro PUF_LINK_TIMEOUT_EN enables the inter-byte RX timeout.
module puf_uart_link #(
   parameter int CHAL_BYTES = 8,
   parameter int RESP_BYTES = 4,
   parameter int TIMEOUT    = 50000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_l,
   puf_uart_link_if.master   lnk
);
   localparam int CW   = 8 * CHAL_BYTES;
   localparam int TXN  = RESP_BYTES + 2;
   localparam int TW   = 8 * TXN;
   localparam int CNTW = $clog2(CHAL_BYTES + 1);
   localparam int LW   = $clog2(TXN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_CHAL,
      S_RX_SUM,
      S_PUF_RUN,
      S_TX_LOAD,
      S_TX_REQ,
      S_TX_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic            rdy_q, rdy_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [7:0]      sum_q, sum_d;
   logic [CW-1:0]   shift_q, shift_d;
   logic [CW-1:0]   chal_q, chal_d;
   logic            start_q, start_d;
   logic            err_q, err_d;
   logic [7:0]      xdata_q, xdata_d;
   logic [TW-1:0]   txbuf_q, txbuf_d;
   logic [LW-1:0]   txleft_q, txleft_d;
   logic            acc;
   logic [7:0]      rsum;

`ifdef PUF_LINK_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT);
   logic [TOW-1:0]  to_q, to_d;
`endif

   assign acc = lnk.rec_readyH & ~rdy_q;

   assign lnk.xmitH         = (state_q == S_TX_REQ);
   assign lnk.xmit_dataH    = xdata_q;
   assign lnk.puf_challenge = chal_q;
   assign lnk.puf_startH    = start_q;
   assign lnk.link_busyH    = (state_q != S_IDLE);
   assign lnk.frame_errH    = err_q;

   // reply checksum: sum of the live response bytes, mod 256
   always_comb begin
      rsum = 8'h00;
      for (int i = 0; i < RESP_BYTES; i++) begin
         rsum = rsum + lnk.puf_response[8*i +: 8];
      end
   end

   // frame FSM: next state, datapath updates and output pulses
   always_comb begin
      state_d  = state_q;
      rdy_d    = lnk.rec_readyH;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      shift_d  = shift_q;
      chal_d   = chal_q;
      start_d  = 1'b0;
      err_d    = 1'b0;
      xdata_d  = xdata_q;
      txbuf_d  = txbuf_q;
      txleft_d = txleft_q;
`ifdef PUF_LINK_TIMEOUT_EN
      to_d     = to_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (acc && lnk.rec_dataH == 8'hA5) begin
               state_d = S_RX_CHAL;
               cnt_d   = '0;
               sum_d   = 8'h00;
`ifdef PUF_LINK_TIMEOUT_EN
               to_d    = '0;
`endif
            end
         end
         S_RX_CHAL: begin
            if (acc) begin
               shift_d      = shift_q << 8;
               shift_d[7:0] = lnk.rec_dataH;
               sum_d        = sum_q + lnk.rec_dataH;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == CNTW'(CHAL_BYTES - 1)) begin
                  state_d = S_RX_SUM;
               end
`ifdef PUF_LINK_TIMEOUT_EN
               to_d = '0;
            end else if (to_q == TOW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + 1'b1;
`endif
            end
         end
         S_RX_SUM: begin
            if (acc) begin
               if (lnk.rec_dataH == sum_q) begin
                  chal_d  = shift_q;
                  start_d = 1'b1;
                  state_d = S_PUF_RUN;
               end else begin
                  err_d    = 1'b1;
                  txbuf_d  = {8'hEE, {(TW-8){1'b0}}};
                  txleft_d = LW'(1);
                  state_d  = S_TX_LOAD;
               end
`ifdef PUF_LINK_TIMEOUT_EN
               to_d = '0;
            end else if (to_q == TOW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + 1'b1;
`endif
            end
         end
         S_PUF_RUN: begin
            if (lnk.puf_doneH) begin
               txbuf_d  = {8'h5A, lnk.puf_response, rsum};
               txleft_d = LW'(TXN);
               state_d  = S_TX_LOAD;
            end
         end
         S_TX_LOAD: begin
            xdata_d  = txbuf_q[TW-1 -: 8];
            txbuf_d  = txbuf_q << 8;
            txleft_d = txleft_q - 1'b1;
            state_d  = S_TX_REQ;
         end
         S_TX_REQ: begin
            if (!lnk.xmit_doneH) begin
               state_d = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            if (lnk.xmit_doneH) begin
               state_d = (txleft_q == '0) ? S_IDLE : S_TX_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         state_q  <= S_IDLE;
         rdy_q    <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= 8'h00;
         shift_q  <= '0;
         chal_q   <= '0;
         start_q  <= 1'b0;
         err_q    <= 1'b0;
         xdata_q  <= 8'h00;
         txbuf_q  <= '0;
         txleft_q <= '0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         shift_q  <= shift_d;
         chal_q   <= chal_d;
         start_q  <= start_d;
         err_q    <= err_d;
         xdata_q  <= xdata_d;
         txbuf_q  <= txbuf_d;
         txleft_q <= txleft_d;
      end
   end

`ifdef PUF_LINK_TIMEOUT_EN
   // inter-byte timeout counter
   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`endif

endmodule

// File: tb/tb_puf_uart_link.sv
// tb_puf_uart_link: frame vectors with a transmit-byte scoreboard,
// plus hand sequences for ignored bytes, reset mid-TX and timeout.
module tb_puf_uart_link;
   logic clk;
   logic rst_l;
   int   checks = 0;
   int   errors = 0;
   int   start_cnt = 0;
   int   err_cnt = 0;
   int   puf_delay = 3;
   logic [15:0] cur_resp = 16'h0;
   logic [7:0]  exp_q[$];

   puf_uart_link_if #(.CHAL_BYTES(2), .RESP_BYTES(2)) lnk ();

   puf_uart_link #(
      .CHAL_BYTES(2),
      .RESP_BYTES(2),
      .TIMEOUT(100)
   ) dut (
      .sys_clk(clk),
      .sys_rst_l(rst_l),
      .lnk(lnk)
   );

   typedef struct {
      int          nrx;
      logic [63:0] rx;
      logic [15:0] resp;
      int          ntx;
      logic [31:0] tx;
      int          starts;
      int          errs;
      logic [15:0] chal;
   } vec_t;

   vec_t vecs[6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (lnk.puf_startH === 1'b1) start_cnt++;
      if (lnk.frame_errH === 1'b1) err_cnt++;
   end

   // PUF core model with first-reply-byte latency check
   initial begin
      lnk.puf_doneH    = 1'b0;
      lnk.puf_response = 16'h0;
      forever begin
         @(negedge clk);
         if (lnk.puf_startH === 1'b1) begin
            repeat (puf_delay) @(negedge clk);
            lnk.puf_response = cur_resp;
            lnk.puf_doneH    = 1'b1;
            @(negedge clk);
            lnk.puf_doneH    = 1'b0;
            lnk.puf_response = ~cur_resp;
            chk("xmit_lat1", {31'b0, lnk.xmitH}, 32'd0);
            @(negedge clk);
            chk("xmit_lat2", {31'b0, lnk.xmitH}, 32'd1);
            chk("first_byte", {24'b0, lnk.xmit_dataH}, 32'h5A);
         end
      end
   end

   // UART transmitter model feeding the scoreboard
   initial begin
      logic [7:0] b;
      logic [7:0] e;
      lnk.xmit_doneH = 1'b1;
      forever begin
         @(negedge clk);
         if (lnk.xmitH === 1'b1 && lnk.xmit_doneH) begin
            b = lnk.xmit_dataH;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_extra: got %h expected none", b);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", {24'b0, b}, {24'b0, e});
            end
            lnk.xmit_doneH = 1'b0;
            repeat (3) @(negedge clk);
            lnk.xmit_doneH = 1'b1;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      lnk.rec_dataH  = b;
      lnk.rec_readyH = 1'b1;
      repeat (2) @(negedge clk);
      lnk.rec_readyH = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || lnk.link_busyH ||
              !lnk.xmit_doneH) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_bound", {31'b0, n < 3000}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int s0 = start_cnt;
      int e0 = err_cnt;
      cur_resp = v.resp;
      for (int i = 0; i < v.ntx; i++) exp_q.push_back(v.tx[31-8*i -: 8]);
      for (int i = 0; i < v.nrx; i++) send_byte(v.rx[63-8*i -: 8]);
      wait_idle();
      chk({tag, "_starts"}, start_cnt - s0, v.starts);
      chk({tag, "_errs"}, err_cnt - e0, v.errs);
      chk({tag, "_chal"}, {16'b0, lnk.puf_challenge}, {16'b0, v.chal});
      chk({tag, "_busy"}, {31'b0, lnk.link_busyH}, 32'd0);
      chk({tag, "_left"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   s0;
      int   e0;
      int   n;
      vecs[0] = '{nrx:4, rx:64'hA512344600000000, resp:16'hBEEF,
                  ntx:4, tx:32'h5ABEEFAD, starts:1, errs:0, chal:16'h1234};
      vecs[1] = '{nrx:4, rx:64'hA512340000000000, resp:16'h0,
                  ntx:1, tx:32'hEE000000, starts:0, errs:1, chal:16'h1234};
      vecs[2] = '{nrx:7, rx:64'h00FF5AA512344600, resp:16'h0102,
                  ntx:4, tx:32'h5A010203, starts:1, errs:0, chal:16'h1234};
      vecs[3] = '{nrx:4, rx:64'hA5A501A600000000, resp:16'hFFFF,
                  ntx:4, tx:32'h5AFFFFFE, starts:1, errs:0, chal:16'hA501};
      vecs[4] = '{nrx:4, rx:64'hA55678CE00000000, resp:16'h8000,
                  ntx:4, tx:32'h5A800080, starts:1, errs:0, chal:16'h5678};
      vecs[5] = '{nrx:4, rx:64'hA500010200000000, resp:16'h0,
                  ntx:1, tx:32'hEE000000, starts:0, errs:1, chal:16'h5678};

      rst_l          = 1'b0;
      lnk.rec_dataH  = 8'h00;
      lnk.rec_readyH = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_xmit", {31'b0, lnk.xmitH}, 32'd0);
      chk("rst_xdata", {24'b0, lnk.xmit_dataH}, 32'd0);
      chk("rst_chal", {16'b0, lnk.puf_challenge}, 32'd0);
      chk("rst_start", {31'b0, lnk.puf_startH}, 32'd0);
      chk("rst_busy", {31'b0, lnk.link_busyH}, 32'd0);
      chk("rst_err", {31'b0, lnk.frame_errH}, 32'd0);
      rst_l = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // bytes arriving during PUF_RUN and TX are ignored
      puf_delay = 20;
      cur_resp  = 16'hBEEF;
      s0 = start_cnt;
      e0 = err_cnt;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hAD);
      send_byte(8'hA5);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h46);
      send_byte(8'h77);
      n = 0;
      while (lnk.xmitH !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("ign_xmit_bound", {31'b0, n < 500}, 32'd1);
      send_byte(8'h88);
      wait_idle();
      chk("ign_starts", start_cnt - s0, 32'd1);
      chk("ign_errs", err_cnt - e0, 32'd0);
      chk("ign_chal", {16'b0, lnk.puf_challenge}, 32'h1234);
      puf_delay = 3;

      // asynchronous reset while xmitH is high
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hAD);
      send_byte(8'hA5);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h46);
      n = 0;
      while (lnk.xmitH !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rst_tx_bound", {31'b0, n < 500}, 32'd1);
      #2;
      rst_l = 1'b0;
      #1;
      chk("arst_xmit", {31'b0, lnk.xmitH}, 32'd0);
      chk("arst_busy", {31'b0, lnk.link_busyH}, 32'd0);
      chk("arst_chal", {16'b0, lnk.puf_challenge}, 32'd0);
      chk("arst_xdata", {24'b0, lnk.xmit_dataH}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      n = 0;
      while (!lnk.xmit_doneH && n < 100) begin
         @(negedge clk);
         n++;
      end
      run_vec(vecs[0], "post_rst");

`ifdef PUF_LINK_TIMEOUT_EN
      // inter-byte timeout in RX_CHAL, then a clean frame
      e0 = err_cnt;
      send_byte(8'hA5);
      @(negedge clk);
      lnk.rec_dataH  = 8'h12;
      lnk.rec_readyH = 1'b1;
      n = 0;
      while (err_cnt == e0 && n < 300) begin
         @(negedge clk);
         n++;
         if (n == 2) lnk.rec_readyH = 1'b0;
      end
      chk("to_seen", {31'b0, err_cnt == e0 + 1}, 32'd1);
      chk("to_window", {31'b0, n >= 100 && n <= 102}, 32'd1);
      @(negedge clk);
      chk("to_idle", {31'b0, lnk.link_busyH}, 32'd0);
      chk("to_chal", {16'b0, lnk.puf_challenge}, 32'h1234);
      repeat (20) @(negedge clk);
      chk("to_no_tx", {31'b0, lnk.xmitH}, 32'd0);
      v = '{nrx:4, rx:64'hA5ABCD7800000000, resp:16'h1357,
            ntx:4, tx:32'h5A13576A, starts:1, errs:0, chal:16'hABCD};
      run_vec(v, "to_next");
`else
      v = vecs[0];
      run_vec(v, "again");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
